// File: rtl/mdr_pkg.sv
// mdr_pkg: shared types and constants for the mdr operand driver
package mdr_pkg;
    localparam int WORD_LENGTH = 16;
    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_ROOT = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;
    typedef enum logic [2:0] {
        IDLE,
        SEND_X,
        WAIT_X,
        SEND_Y,
        WAIT_Y,
        START,
        WAIT_RDY,
        RESP
    } drv_state_e;
endpackage

// File: rtl/mdr_operand_driver_ack_watchdog.sv
// ack_watchdog: saturating wait counter, expired once ACK_TIMEOUT cycles have elapsed
//   clk, reset (async active-low), clr (zero the count), en (count), expired (count == ACK_TIMEOUT)
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [15:0] cnt;
    assign expired = cnt == 16'(ACK_TIMEOUT);
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 16'd1;
endmodule

// File: rtl/mdr_operand_driver.sv
// mdr_operand_driver: serialises an (X, Y, op) request onto the mdr loader bus and returns the core result
//   req_*  : parallel request handshake (req_ready decoded from state)
//   data/op/load/start : registered drive towards loader and core
//   loadX/loadY/ready/result/remainder/sign : acknowledgements and core outputs
//   rsp_*  : registered response handshake; rsp_timeout marks an aborted operation
module mdr_operand_driver #(
    parameter int WORD_LENGTH = mdr_pkg::WORD_LENGTH,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WORD_LENGTH-1:0] req_x,
    input  logic [WORD_LENGTH-1:0] req_y,
    input  logic [1:0]             req_op,
    output logic [WORD_LENGTH-1:0] data,
    output logic [1:0]             op,
    output logic                   load,
    output logic                   start,
    input  logic                   loadX,
    input  logic                   loadY,
    input  logic                   ready,
    input  logic [WORD_LENGTH-1:0] result,
    input  logic [WORD_LENGTH-1:0] remainder,
    input  logic                   sign,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_LENGTH-1:0] rsp_result,
    output logic [WORD_LENGTH-1:0] rsp_remainder,
    output logic                   rsp_sign,
    output logic                   rsp_timeout
);
    import mdr_pkg::*;
    drv_state_e             state;
    logic [WORD_LENGTH-1:0] y_q;
    logic                   ready_q;
    logic                   rise;
    logic                   waiting;
    logic                   ack;
    logic                   expired;
    logic                   abort;
    assign req_ready = state == IDLE;
    // only a fresh rising edge counts, so a ready left high by the last operation is ignored
    assign rise      = ready & ~ready_q;
    assign waiting   = state inside {WAIT_X, WAIT_Y, WAIT_RDY};
    // an acknowledgement in the expiry cycle takes priority over the abort
    always_comb begin
        ack   = (state == WAIT_X) ? loadX : (state == WAIT_Y) ? loadY : rise;
        abort = waiting && expired && !ack;
    end
    ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    (!waiting),
        .en     (waiting),
        .expired(expired)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            y_q           <= '0;
            ready_q       <= 1'b0;
            data          <= '0;
            op            <= '0;
            load          <= 1'b0;
            start         <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_sign      <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            ready_q <= ready;
            if (abort) begin
                rsp_valid     <= 1'b1;
                rsp_timeout   <= 1'b1;
                rsp_result    <= '0;
                rsp_remainder <= '0;
                rsp_sign      <= 1'b0;
                state         <= RESP;
            end else begin
                case (state)
                    IDLE: if (req_valid) begin
                        y_q   <= req_y;
                        op    <= req_op;
                        data  <= req_x;
                        load  <= 1'b1;
                        state <= SEND_X;
                    end
                    SEND_X: begin
                        load  <= 1'b0;
                        state <= WAIT_X;
                    end
                    WAIT_X: if (loadX) begin
                        data  <= y_q;
                        load  <= 1'b1;
                        state <= SEND_Y;
                    end
                    SEND_Y: begin
                        load  <= 1'b0;
                        state <= WAIT_Y;
                    end
                    WAIT_Y: if (loadY) begin
                        start <= 1'b1;
                        state <= START;
                    end
                    START: begin
                        start <= 1'b0;
                        state <= WAIT_RDY;
                    end
                    WAIT_RDY: if (rise) begin
                        rsp_valid     <= 1'b1;
                        rsp_result    <= result;
                        rsp_remainder <= remainder;
                        rsp_sign      <= sign;
                        state         <= RESP;
                    end
                    RESP: if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdr_operand_driver.sv
// tb_mdr_operand_driver: directed self-checking bench for mdr_operand_driver
module tb_mdr_operand_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic [1:0]  req_op = '0;
    logic [15:0] data;
    logic [1:0]  op;
    logic        load, start;
    logic        loadx = 1'b0, loady = 1'b0, ready = 1'b0;
    logic [15:0] result = '0, remainder = '0;
    logic        sign = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [15:0] rsp_result, rsp_remainder;
    logic        rsp_sign, rsp_timeout;
    logic        t_req_valid = 1'b0, t_req_ready;
    logic [15:0] t_data;
    logic [1:0]  t_op;
    logic        t_load, t_start;
    logic        t_loadx = 1'b0, t_loady = 1'b0, t_ready = 1'b0;
    logic [15:0] t_res = 16'hFFFF, t_rem = 16'hFFFF;
    logic        t_sign = 1'b1;
    logic        t_rsp_valid, t_rsp_ready = 1'b0;
    logic [15:0] t_rsp_result, t_rsp_remainder;
    logic        t_rsp_sign, t_rsp_timeout;
    int          vectors = 0;
    int          miscompares = 0;
    int          nld = 0, nst = 0;
    logic [15:0] ld_d [4];
    always #5 clk = ~clk;
    mdr_operand_driver #(.WORD_LENGTH(16), .ACK_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op), .data(data), .op(op),
        .load(load), .start(start), .loadX(loadx), .loadY(loady), .ready(ready),
        .result(result), .remainder(remainder), .sign(sign), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_remainder(rsp_remainder),
        .rsp_sign(rsp_sign), .rsp_timeout(rsp_timeout)
    );
    mdr_operand_driver #(.WORD_LENGTH(16), .ACK_TIMEOUT(8)) dut_to (
        .clk(clk), .reset(reset), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op), .data(t_data), .op(t_op),
        .load(t_load), .start(t_start), .loadX(t_loadx), .loadY(t_loady), .ready(t_ready),
        .result(t_res), .remainder(t_rem), .sign(t_sign), .rsp_valid(t_rsp_valid),
        .rsp_ready(t_rsp_ready), .rsp_result(t_rsp_result), .rsp_remainder(t_rsp_remainder),
        .rsp_sign(t_rsp_sign), .rsp_timeout(t_rsp_timeout)
    );
    always @(posedge clk) begin
        if (load) begin
            if (nld < 4) ld_d[nld] <= data;
            nld <= nld + 1;
        end
        if (start) nst <= nst + 1;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o);
        req_x = x;
        req_y = y;
        req_op = o;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
    endtask
    // entered in the cycle the X load strobe is visible; returns in the first RESP cycle
    task automatic body(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o,
                        input int lat, input bit stale,
                        input logic [15:0] res, input logic [15:0] rem, input logic sg);
        chk("load_x", load, 1);
        chk("data_x", data, x);
        chk("op_out", op, o);
        chk("req_ready_busy", req_ready, 0);
        tick;
        chk("wait_x_load", load, 0);
        chk("wait_x_data", data, x);
        loadx = 1'b1;
        tick;
        loadx = 1'b0;
        chk("load_y", load, 1);
        chk("data_y", data, y);
        tick;
        chk("wait_y_load", load, 0);
        loady = 1'b1;
        tick;
        loady = 1'b0;
        chk("start_pulse", start, 1);
        tick;
        chk("start_drop", start, 0);
        if (stale) begin
            repeat (3) tick;
            chk("stale_ignored", rsp_valid, 0);
            ready = 1'b0;
            tick;
        end else begin
            repeat (lat - 1) tick;
            chk("no_early_rsp", rsp_valid, 0);
        end
        result = res;
        remainder = rem;
        sign = sg;
        ready = 1'b1;
        tick;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_result", rsp_result, res);
        chk("rsp_remainder", rsp_remainder, rem);
        chk("rsp_sign", rsp_sign, sg);
        chk("rsp_timeout", rsp_timeout, 0);
    endtask
    initial begin
        int waited;
        bit started;
        tick;
        tick;
        chk("rst_data", data, 0);
        chk("rst_load", load, 0);
        chk("rst_start", start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        reset = 1'b1;
        tick;
        chk("rst_req_ready", req_ready, 1);
        // nominal operation, then back-pressure on the response
        issue(16'h0007, 16'h0003, 2'd0);
        body(16'h0007, 16'h0003, 2'd0, 20, 1'b0, 16'h0015, 16'h0000, 1'b0);
        chk("nom_load_count", nld, 2);
        chk("nom_start_count", nst, 1);
        chk("nom_seq0", ld_d[0], 16'h0007);
        chk("nom_seq1", ld_d[1], 16'h0003);
        result = 16'h0BEE;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 16'h0015);
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_idle", req_ready, 1);
        // stale ready: high before start, must fall and rise again
        result = 16'h00AA;
        tick;
        issue(16'h0009, 16'h0004, 2'd1);
        body(16'h0009, 16'h0004, 2'd1, 0, 1'b1, 16'h0002, 16'h0001, 1'b0);
        rsp_ready = 1'b1;
        ready = 1'b0;
        tick;
        chk("stale_idle", req_ready, 1);
        // back-to-back with rsp_ready tied high
        issue(16'h0010, 16'h0020, 2'd3);
        body(16'h0010, 16'h0020, 2'd3, 2, 1'b0, 16'h0030, 16'h0005, 1'b1);
        ready = 1'b0;
        req_x = 16'h0011;
        req_y = 16'h0022;
        req_op = 2'd1;
        req_valid = 1'b1;
        tick;
        chk("b2b_idle", req_ready, 1);
        chk("b2b_rsp_drop", rsp_valid, 0);
        chk("b2b_no_load", load, 0);
        tick;
        req_valid = 1'b0;
        body(16'h0011, 16'h0022, 2'd1, 3, 1'b0, 16'h0033, 16'h0000, 1'b0);
        tick;
        rsp_ready = 1'b0;
        ready = 1'b0;
        chk("b2b_done", req_ready, 1);
        // reset while waiting for the core
        issue(16'h0055, 16'h0066, 2'd2);
        loadx = 1'b1;
        tick;
        loadx = 1'b0;
        tick;
        loady = 1'b1;
        tick;
        loady = 1'b0;
        tick;
        chk("mid_op_busy", req_ready, 0);
        #3 reset = 1'b0;
        #1;
        chk("arst_data", data, 0);
        chk("arst_op", op, 0);
        chk("arst_load", load, 0);
        chk("arst_start", start, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_result", rsp_result, 0);
        chk("arst_rsp_timeout", rsp_timeout, 0);
        tick;
        reset = 1'b1;
        tick;
        chk("arst_no_rsp", rsp_valid, 0);
        issue(16'h0012, 16'h0034, 2'd1);
        body(16'h0012, 16'h0034, 2'd1, 3, 1'b0, 16'h0046, 16'h0002, 1'b0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        ready = 1'b0;
        // watchdog instance: ack in the expiry cycle wins, then loadY never comes
        req_x = 16'h0005;
        req_y = 16'h0006;
        req_op = 2'd0;
        t_req_valid = 1'b1;
        tick;
        t_req_valid = 1'b0;
        chk("to_load_x", t_load, 1);
        tick;
        repeat (8) tick;
        chk("to_still_wait_x", t_rsp_valid, 0);
        t_loadx = 1'b1;
        tick;
        t_loadx = 1'b0;
        chk("to_ack_wins_load", t_load, 1);
        chk("to_ack_wins_data", t_data, 16'h0006);
        chk("to_ack_wins_rsp", t_rsp_valid, 0);
        waited = 0;
        started = 1'b0;
        while (!t_rsp_valid && waited < 40) begin
            tick;
            waited++;
            if (t_start) started = 1'b1;
        end
        chk("to_rsp_valid", t_rsp_valid, 1);
        chk("to_never_start", started, 0);
        chk("to_flag", t_rsp_timeout, 1);
        chk("to_result", t_rsp_result, 0);
        chk("to_remainder", t_rsp_remainder, 0);
        chk("to_sign", t_rsp_sign, 0);
        t_rsp_ready = 1'b1;
        tick;
        t_rsp_ready = 1'b0;
        chk("to_flag_clear", t_rsp_timeout, 0);
        chk("to_idle", t_req_ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
